serial_cla_adder: RTL and testbench



---
 rtl/serial_cla_adder_pkg.sv | 20 ++
 rtl/serial_cla_adder_cla.sv | 36 +++
 rtl/serial_cla_adder.sv | 132 +++++++++++++
 tb/tb_serial_cla_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_cla_adder_pkg.sv
// Shared definitions for the nibble-serial carry-look-ahead adder.
// Holds the nibble width, FSM state encoding and index-width helper.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble index width: clog2 of the nibble count, never narrower than 1 bit.
  function automatic int idxWidth(input int width);
    int nib;
    nib = width / NIBBLE_W;
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/serial_cla_adder_cla.sv
// 4-bit carry-look-ahead slice: flat generate/propagate carry equations,
// producing the nibble sum and the group carry-out.
module carry_look_ahead_gen
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_carry
);

  logic [NIBBLE_W-1:0] w_gen;
  logic [NIBBLE_W-1:0] w_prop;
  logic [NIBBLE_W:0]   w_carry;

  assign w_gen  = i_a & i_b;
  assign w_prop = i_a ^ i_b;

  // Every carry is a two-level function of g/p and cin, no ripple chain.
  assign w_carry[0] = i_cin;
  assign w_carry[1] = w_gen[0] | (w_prop[0] & i_cin);
  assign w_carry[2] = w_gen[1] | (w_prop[1] & w_gen[0])
                    | (w_prop[1] & w_prop[0] & i_cin);
  assign w_carry[3] = w_gen[2] | (w_prop[2] & w_gen[1])
                    | (w_prop[2] & w_prop[1] & w_gen[0])
                    | (w_prop[2] & w_prop[1] & w_prop[0] & i_cin);
  assign w_carry[4] = w_gen[3] | (w_prop[3] & w_gen[2])
                    | (w_prop[3] & w_prop[2] & w_gen[1])
                    | (w_prop[3] & w_prop[2] & w_prop[1] & w_gen[0])
                    | (w_prop[3] & w_prop[2] & w_prop[1] & w_prop[0] & i_cin);

  assign o_sum   = w_prop ^ w_carry[NIBBLE_W-1:0];
  assign o_carry = w_carry[NIBBLE_W];

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA slice, one nibble per
// clock, with valid/ready handshakes on the operand and result sides.
module serial_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idxWidth(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_badWidth
    $error("serial_cla_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t              r_state;
  state_t              w_nextState;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_cout;
  logic                r_ovf;
  logic [IW-1:0]       r_idx;
  logic [NIBBLE_W-1:0] w_aNib;
  logic [NIBBLE_W-1:0] w_bNib;
  logic [NIBBLE_W-1:0] w_sliceSum;
  logic                w_sliceCarry;
  logic                w_accept;
  logic                w_lastNib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_nextState = RUN;
      RUN:     if (w_lastNib) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign w_accept  = in_valid && in_ready;
  assign w_lastNib = (r_idx == LAST_IDX);

  // Constant-index mux keeps every part-select static.
  always_comb begin
    w_aNib = '0;
    w_bNib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IW'(n)) begin
        w_aNib = r_a[n*NIBBLE_W +: NIBBLE_W];
        w_bNib = r_b[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  carry_look_ahead_gen u_slice (
    .i_a     (w_aNib),
    .i_b     (w_bNib),
    .i_cin   (r_carry),
    .o_sum   (w_sliceSum),
    .o_carry (w_sliceCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (r_idx == IW'(n)) r_sum[n*NIBBLE_W +: NIBBLE_W] <= w_sliceSum;
          end
          r_carry <= w_sliceCarry;
          // The index parks on the last nibble instead of wrapping.
          if (w_lastNib) begin
            r_cout <= w_sliceCarry;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_sliceSum[NIBBLE_W-1] != r_a[WIDTH-1]);
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed bench for serial_cla_adder: vector table at WIDTH=16 plus
// backpressure, mid-run reset, early out_ready and WIDTH=4 sequences.
module tb_serial_cla_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout, ovf;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, ovf4;

  int total = 0;
  int bad   = 0;

  serial_cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands for one accept edge,
  // then scrambles the inputs to prove they are sampled only at acceptance.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic vcin);
    int waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkValue("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vcin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    checkValue("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expSum,
                             input logic expCout, input logic expOvf);
    int lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkValue({name, "_latency"}, 32'(lat), 32'd4);
    checkValue({name, "_sum"}, 32'(sum), 32'(expSum));
    checkValue({name, "_cout"}, 32'(cout), 32'(expCout));
    checkValue({name, "_ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  task automatic completeResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkValue({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    checkValue({name, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] holdSum;
    logic        holdCout, holdOvf;
    int          pulses;
    int          lat4;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_in_ready", 32'(in_ready), 32'd1);
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_sum", 32'(sum), 32'd0);
    checkValue("rst_cout", 32'(cout), 32'd0);
    checkValue("rst_ovf", 32'(ovf), 32'd0);
    checkValue("rst_in_ready4", 32'(in_ready4), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      checkOutput($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      completeResult($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and new operands must be refused.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("bp", 16'h0000, 1'b1, 1'b0);
    holdSum = sum; holdCout = cout; holdOvf = ovf;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'b1;
      @(posedge clk); #1;
      checkValue("bp_sum_hold", 32'(sum), 32'h0000);
      checkValue("bp_cout_hold", 32'(cout), 32'd1);
      checkValue("bp_ovf_hold", 32'(ovf), 32'(holdOvf));
      checkValue("bp_in_ready", 32'(in_ready), 32'd0);
      checkValue("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    completeResult("bp");
    applyStimulus(16'h2222, 16'h1111, 1'b1);
    checkOutput("bp_next", 16'h3334, 1'b0, 1'b0);
    completeResult("bp_next");

    // out_ready already high: DONE should last a single cycle.
    out_ready = 1'b1;
    applyStimulus(16'h00F0, 16'h0010, 1'b0);
    checkOutput("early_rdy", 16'h0100, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkValue("early_rdy_out_valid_drop", 32'(out_valid), 32'd0);
    checkValue("early_rdy_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Reset while idx=2: partial sum 0x0055 must be discarded.
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkValue("midrst_in_ready", 32'(in_ready), 32'd1);
    checkValue("midrst_out_valid", 32'(out_valid), 32'd0);
    checkValue("midrst_sum", 32'(sum), 32'd0);
    checkValue("midrst_cout", 32'(cout), 32'd0);
    checkValue("midrst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checkValue("midrst_no_out_valid", 32'(pulses), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    checkOutput("post_rst", 16'h0100, 1'b0, 1'b0);
    completeResult("post_rst");

    // WIDTH=4 instance: single-nibble latency.
    in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    checkValue("w4_in_ready_after_accept", 32'(in_ready4), 32'd0);
    lat4 = 0;
    while (!out_valid4 && lat4 < 10) begin
      @(posedge clk); #1;
      lat4++;
    end
    checkValue("w4_latency", 32'(lat4), 32'd1);
    checkValue("w4_sum", 32'(sum4), 32'h2);
    checkValue("w4_cout", 32'(cout4), 32'd1);
    checkValue("w4_ovf", 32'(ovf4), 32'd1);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    checkValue("w4_in_ready_after_hs", 32'(in_ready4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
